// File: rtl/audio_frame_buffer.sv
// ---------------------------------------------------------------------------
// AudioFrameBuffer: framing stage ahead of the 16-point FFT.
//
// Streaming 16-bit samples are written into a 16-entry circular history.
// Every HOP accepted samples a frame becomes due. While a frame is due, it
// launches on the first edge where the FFT reports done and no launch pulse
// is already in flight. On launch, the newest 16 samples are copied onto
// t0..t15 in time order, and new_t pulses for one cycle.
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   sample_in    in   16-bit two's complement audio sample (not modified)
//   sample_valid in   sample_in is accepted on every edge where this is high
//   fft_done     in   FFT idle/complete; a frame may launch only while high
//   t0..t15      out  frame taps, t0 oldest and t15 newest; held between launches
//   new_t        out  one-cycle pulse following each snapshot edge
//   overrun      out  sticky; a due frame was superseded before it launched
//   frame_count  out  number of launched frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module audio_frame_buffer #(
    parameter int HOP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        fft_done,
    output logic [15:0] t0,
    output logic [15:0] t1,
    output logic [15:0] t2,
    output logic [15:0] t3,
    output logic [15:0] t4,
    output logic [15:0] t5,
    output logic [15:0] t6,
    output logic [15:0] t7,
    output logic [15:0] t8,
    output logic [15:0] t9,
    output logic [15:0] t10,
    output logic [15:0] t11,
    output logic [15:0] t12,
    output logic [15:0] t13,
    output logic [15:0] t14,
    output logic [15:0] t15,
    output logic        new_t,
    output logic        overrun,
    output logic [7:0]  frame_count
);

    localparam logic [4:0] HopW = 5'(HOP);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ram_q [16];
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [4:0]  fill_cnt_q, fill_cnt_d;
    logic [4:0]  hop_cnt_q, hop_cnt_d;
    logic [15:0] t_q [16];
    logic [15:0] t_d [16];
    logic        new_t_q, new_t_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  frame_count_q, frame_count_d;

    logic        launch;
    logic [4:0]  hop_sum;
    logic        hop_hit;

    // History RAM. Its contents are not reset: the fill phase overwrites
    // every entry before the first snapshot reads it. wr_ptr always points
    // at the oldest entry, which is also the next one to be written.
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            ram_q[wr_ptr_q] <= sample_in;
        end
    end

    // Launch decision and hop accounting. On a launch edge, the hop count
    // restarts from zero. A sample accepted on that same edge is therefore
    // the first sample of the next hop. With HOP = 1, that sample alone
    // makes the next frame due at once. The new_t guard then keeps the two
    // launches at least one idle cycle apart.
    always_comb begin
        launch  = (state_q == PEND) && fft_done && !new_t_q;
        hop_sum = (launch ? 5'd0 : hop_cnt_q) + {4'd0, sample_valid};
        hop_hit = (hop_sum == HopW);

        state_d       = state_q;
        hop_cnt_d     = hop_cnt_q;
        overrun_d     = overrun_q;
        new_t_d       = launch;
        frame_count_d = frame_count_q + {7'd0, launch};
        wr_ptr_d      = wr_ptr_q + {3'd0, sample_valid};
        fill_cnt_d    = fill_cnt_q;

        if (sample_valid && (fill_cnt_q != 5'd16)) begin
            fill_cnt_d = fill_cnt_q + 5'd1;
        end

        case (state_q)
            FILL: begin
                hop_cnt_d = 5'd0;
                if (sample_valid && (fill_cnt_q == 5'd15)) begin
                    state_d = PEND;
                end
            end
            RUN: begin
                if (hop_hit) begin
                    state_d   = PEND;
                    hop_cnt_d = 5'd0;
                end else begin
                    hop_cnt_d = hop_sum;
                end
            end
            PEND: begin
                if (launch) begin
                    if (hop_hit) begin
                        hop_cnt_d = 5'd0;
                    end else begin
                        state_d   = RUN;
                        hop_cnt_d = hop_sum;
                    end
                end else if (hop_hit) begin
                    // A further full hop arrived before the due frame could
                    // launch. The frame stays due and will show the newest
                    // samples when it finally goes out.
                    overrun_d = 1'b1;
                    hop_cnt_d = 5'd0;
                end else begin
                    hop_cnt_d = hop_sum;
                end
            end
            default: begin
                state_d   = FILL;
                hop_cnt_d = 5'd0;
            end
        endcase
    end

    // Snapshot. Tap i reads slot (wr_ptr + i) mod 16 of the RAM contents
    // from before the edge. As a result, a sample written on the launch
    // edge is not part of this frame.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            t_d[i] = launch ? ram_q[wr_ptr_q + 4'(i)] : t_q[i];
        end
    end

    // Control state and registered outputs. Reset discards any pending
    // frame, and the block must see 16 fresh samples before it launches again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            wr_ptr_q      <= 4'd0;
            fill_cnt_q    <= 5'd0;
            hop_cnt_q     <= 5'd0;
            new_t_q       <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                t_q[i] <= 16'd0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_cnt_q    <= fill_cnt_d;
            hop_cnt_q     <= hop_cnt_d;
            new_t_q       <= new_t_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            for (int i = 0; i < 16; i++) begin
                t_q[i] <= t_d[i];
            end
        end
    end

    assign t0          = t_q[0];
    assign t1          = t_q[1];
    assign t2          = t_q[2];
    assign t3          = t_q[3];
    assign t4          = t_q[4];
    assign t5          = t_q[5];
    assign t6          = t_q[6];
    assign t7          = t_q[7];
    assign t8          = t_q[8];
    assign t9          = t_q[9];
    assign t10         = t_q[10];
    assign t11         = t_q[11];
    assign t12         = t_q[12];
    assign t13         = t_q[13];
    assign t14         = t_q[14];
    assign t15         = t_q[15];
    assign new_t       = new_t_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for audio_frame_buffer.
//
// Two instances are used: index 0 runs with HOP = 4 and index 1 with HOP = 1.
// Only one instance is exercised at a time, and the other is held in reset.
// A cycle model runs alongside each instance. It keeps a shift-register copy
// of the sample history. When the model decides a frame launches, it pushes
// the expected frame and frame_count onto a queue. The queue entry is popped
// when the instance raises new_t.
// ---------------------------------------------------------------------------
module tb_audio_frame_buffer;

    logic        clk = 1'b0;
    logic        rstD  [2];
    logic        vldD  [2];
    logic [15:0] smpD  [2];
    logic        doneD [2];

    logic [15:0] tOut  [2][16];
    logic        newT  [2];
    logic        overOut [2];
    logic [7:0]  fcOut [2];

    int checkCount = 0;
    int passCount  = 0;

    // Model state, indexed by instance.
    logic [15:0] mHist [2][16];
    int          mFill [2];
    int          mHop  [2];
    bit          mPend [2];
    bit          mNewT [2];
    bit          mOver [2];
    logic [7:0]  mFrames [2];
    logic [255:0] heldFrame [2];
    logic [263:0] expQ [$];

    logic        prevNewT = 1'b0;
    logic [7:0]  prevFc   = 8'd0;
    bit          sawWrap  = 1'b0;

    // Clock generation
    always #5 clk = ~clk;

    // Two instances differing only in HOP
    for (genvar g = 0; g < 2; g++) begin : gDut
        audio_frame_buffer #(.HOP((g == 0) ? 4 : 1)) dut (
            .clk          (clk),
            .reset        (rstD[g]),
            .sample_in    (smpD[g]),
            .sample_valid (vldD[g]),
            .fft_done     (doneD[g]),
            .t0           (tOut[g][0]),
            .t1           (tOut[g][1]),
            .t2           (tOut[g][2]),
            .t3           (tOut[g][3]),
            .t4           (tOut[g][4]),
            .t5           (tOut[g][5]),
            .t6           (tOut[g][6]),
            .t7           (tOut[g][7]),
            .t8           (tOut[g][8]),
            .t9           (tOut[g][9]),
            .t10          (tOut[g][10]),
            .t11          (tOut[g][11]),
            .t12          (tOut[g][12]),
            .t13          (tOut[g][13]),
            .t14          (tOut[g][14]),
            .t15          (tOut[g][15]),
            .new_t        (newT[g]),
            .overrun      (overOut[g]),
            .frame_count  (fcOut[g])
        );
    end

    // Single comparison point; counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model history packed as t0 in the top 16 bits down to t15 at the bottom
    function automatic logic [255:0] packHist(input int d);
        logic [255:0] f;
        for (int i = 0; i < 16; i++) begin
            f[255 - 16*i -: 16] = mHist[d][i];
        end
        return f;
    endfunction

    function automatic logic [255:0] packDut(input int d);
        logic [255:0] f;
        for (int i = 0; i < 16; i++) begin
            f[255 - 16*i -: 16] = tOut[d][i];
        end
        return f;
    endfunction

    // Advance the model across one rising edge, using the inputs driven for that edge
    task automatic modelEdge(input int d, input logic r, input logic v, input logic [15:0] s, input logic dn);
        int hop;
        int cnt;
        bit launch;
        hop = (d == 0) ? 4 : 1;
        if (r) begin
            mPend[d]     = 1'b0;
            mNewT[d]     = 1'b0;
            mOver[d]     = 1'b0;
            mFrames[d]   = 8'd0;
            mHop[d]      = 0;
            mFill[d]     = 0;
            heldFrame[d] = '0;
            return;
        end
        launch = mPend[d] && dn && !mNewT[d];
        if (launch) begin
            mFrames[d] = mFrames[d] + 8'd1;
            expQ.push_back({mFrames[d], packHist(d)});
        end
        cnt = (launch ? 0 : mHop[d]) + (v ? 1 : 0);
        if (mFill[d] < 16) begin
            if (v) begin
                mFill[d]++;
                if (mFill[d] == 16) begin
                    mPend[d] = 1'b1;
                    mHop[d]  = 0;
                end
            end
        end else if (cnt == hop) begin
            if (mPend[d] && !launch) mOver[d] = 1'b1;
            mPend[d] = 1'b1;
            mHop[d]  = 0;
        end else begin
            if (launch) mPend[d] = 1'b0;
            mHop[d] = cnt;
        end
        if (v) begin
            for (int i = 0; i < 15; i++) mHist[d][i] = mHist[d][i+1];
            mHist[d][15] = s;
        end
        mNewT[d] = launch;
    endtask

    // Compare one instance against the model, one time unit after the edge
    task automatic sampleOutputs(input int d);
        logic [255:0] obsF;
        logic [263:0] e;
        bit contiguous;
        obsF = packDut(d);
        checkOutput("new_t", {255'd0, newT[d]}, {255'd0, mNewT[d]});
        checkOutput("overrun", {255'd0, overOut[d]}, {255'd0, mOver[d]});
        if (newT[d] === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedFrame", 256'd1, 256'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("frame", obsF, e[255:0]);
                checkOutput("frame_count", {248'd0, fcOut[d]}, {248'd0, e[263:256]});
                heldFrame[d] = e[255:0];
            end
            if (d == 1) begin
                contiguous = 1'b1;
                for (int i = 0; i < 15; i++) begin
                    if (tOut[1][i+1] !== tOut[1][i] + 16'd1) contiguous = 1'b0;
                end
                checkOutput("contiguous", {255'd0, contiguous}, 256'd1);
                if (prevFc == 8'd255 && fcOut[1] == 8'd0) sawWrap = 1'b1;
                prevFc = fcOut[1];
            end
        end else begin
            checkOutput("hold", obsF, heldFrame[d]);
            checkOutput("frame_count", {248'd0, fcOut[d]}, {248'd0, mFrames[d]});
        end
        if (d == 1) begin
            checkOutput("newTBackToBack", {255'd0, prevNewT & newT[1]}, 256'd0);
            prevNewT = newT[1];
        end
    endtask

    // Drive one cycle of inputs to instance d, step the model, then check
    task automatic applyStimulus(input int d, input logic r, input logic v, input logic [15:0] s, input logic dn);
        @(negedge clk);
        rstD[d]  = r;
        vldD[d]  = v;
        smpD[d]  = s;
        doneD[d] = dn;
        modelEdge(d, r, v, s, dn);
        @(posedge clk);
        #1;
        sampleOutputs(d);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstD[k]  = 1'b1;
            vldD[k]  = 1'b0;
            smpD[k]  = 16'd0;
            doneD[k] = 1'b1;
            for (int i = 0; i < 16; i++) mHist[k][i] = 16'd0;
        end

        $display("[TB] HOP=4: reset and fill");
        repeat (2) applyStimulus(0, 1'b1, 1'b0, 16'd0, 1'b1);
        for (int s = 1; s <= 20; s++) applyStimulus(0, 1'b0, 1'b1, 16'(s), 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b1);

        $display("[TB] HOP=4: done gating");
        for (int s = 21; s <= 24; s++) applyStimulus(0, 1'b0, 1'b1, 16'(s), 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c < 3) applyStimulus(0, 1'b0, 1'b1, 16'(25 + c), 1'b0);
            else       applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b0);
        end
        applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b1);

        $display("[TB] HOP=4: overrun");
        for (int s = 28; s <= 35; s++) applyStimulus(0, 1'b0, 1'b1, 16'(s), 1'b0);
        repeat (3) applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b0);
        repeat (2) applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b1);

        $display("[TB] HOP=4: reset while pending");
        for (int s = 36; s <= 39; s++) applyStimulus(0, 1'b0, 1'b1, 16'(s), 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'd0, 1'b0);
        repeat (2) applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b1);
        for (int s = 40; s <= 55; s++) applyStimulus(0, 1'b0, 1'b1, 16'(s), 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b1);

        $display("[TB] HOP=4: launch coinciding with superseding sample");
        for (int s = 56; s <= 62; s++) applyStimulus(0, 1'b0, 1'b1, 16'(s), 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 16'd63, 1'b1);
        repeat (2) applyStimulus(0, 1'b0, 1'b0, 16'd0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 16'd0, 1'b1);

        $display("[TB] HOP=1: continuous stream with pointer and counter wrap");
        repeat (2) applyStimulus(1, 1'b1, 1'b0, 16'd0, 1'b1);
        for (int s = 1; s <= 620; s++) applyStimulus(1, 1'b0, 1'b1, 16'(s), 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 16'd0, 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 16'd0, 1'b1);

        checkOutput("frameCountWrapped", {255'd0, sawWrap}, 256'd1);
        checkOutput("scoreboardEmpty", 256'(expQ.size()), 256'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
